// File: rtl/hyper_burst_splitter.sv
// hyper_burst_splitter
// Splits linear 16-bit-word burst commands into HyperBus PHY transactions that
// never cross a chip boundary and never exceed MaxBurstWords words.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   in_valid_i / in_ready_o       command handshake (ready only while idle)
//   in_addr_i, in_len_i           start byte address, length as words-1
//   in_write_i                    1 = write, 0 = read
//   out_valid_o / out_ready_i     PHY transaction handshake
//   out_cs_o, out_addr_o          chip index and chip-local byte address
//   out_len_o, out_write_o        words-1 of this transaction, direction
//   out_last_o                    final transaction of the command
//   err_o                         one-cycle pulse when a command is dropped
module hyper_burst_splitter #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned LenWidth      = 16,
    parameter int unsigned MaxBurstWords = 256,
    parameter int unsigned ChipAddrBits  = 23,
    parameter int unsigned NumChips      = 2,
    localparam int unsigned CsWidth      = (NumChips > 1) ? $clog2(NumChips) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [AddrWidth-1:0]    in_addr_i,
    input  logic [LenWidth-1:0]     in_len_i,
    input  logic                    in_write_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [CsWidth-1:0]      out_cs_o,
    output logic [ChipAddrBits-1:0] out_addr_o,
    output logic [LenWidth-1:0]     out_len_o,
    output logic                    out_write_o,
    output logic                    out_last_o,
    output logic                    err_o
);

    localparam int unsigned RemW   = LenWidth + 1;
    localparam int unsigned BndW   = ChipAddrBits + 1;
    localparam int unsigned MaxW   = $clog2(MaxBurstWords + 1);
    localparam int unsigned WideW0 = (RemW > BndW) ? RemW : BndW;
    localparam int unsigned WideW  = (WideW0 > MaxW) ? WideW0 : MaxW;

    typedef enum logic [1:0] {IDLE, CALC, EMIT} state_e;

    state_e                  state_q;
    logic [CsWidth-1:0]      cur_chip_q;
    logic [ChipAddrBits-1:0] cur_local_q;
    logic [RemW-1:0]         rem_q;
    logic [RemW-1:0]         chunk_q;
    logic                    write_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [CsWidth-1:0]      out_cs_q;
    logic [ChipAddrBits-1:0] out_addr_q;
    logic [LenWidth-1:0]     out_len_q;
    logic                    out_write_q;
    logic                    out_last_q;
    logic                    err_q;

    logic [CsWidth-1:0]      in_chip_d;
    logic                    in_bad_d;
    logic [BndW-1:0]         span_d;
    logic [BndW-1:0]         to_bnd_d;
    logic [WideW-1:0]        rem_w_d;
    logic [WideW-1:0]        max_w_d;
    logic [WideW-1:0]        bnd_w_d;
    logic [WideW-1:0]        chunk_w_d;
    logic [RemW-1:0]         chunk_d;
    logic [ChipAddrBits-1:0] next_local_d;
    logic [CsWidth-1:0]      next_chip_d;
    logic                    unused_addr_bits;

    // Bits above the chip field and byte bit 0 carry no meaning here.
    assign unused_addr_bits = ^in_addr_i;

    assign in_chip_d = in_addr_i[ChipAddrBits +: CsWidth];
    assign in_bad_d  = 32'(in_chip_d) >= NumChips;

    // Words left before the chip boundary; cur_local is always even.
    assign span_d   = (BndW'(1) << ChipAddrBits) - BndW'(cur_local_q);
    assign to_bnd_d = span_d >> 1;

    assign rem_w_d = WideW'(rem_q);
    assign max_w_d = WideW'(MaxBurstWords);
    assign bnd_w_d = WideW'(to_bnd_d);

    // chunk = min(remaining, max burst, words to boundary)
    always_comb begin
        chunk_w_d = rem_w_d;
        if (max_w_d < chunk_w_d) chunk_w_d = max_w_d;
        if (bnd_w_d < chunk_w_d) chunk_w_d = bnd_w_d;
    end

    // chunk never exceeds rem_q, so it always fits RemW bits.
    assign chunk_d = RemW'(chunk_w_d);

    // A chunk ends at most exactly on the boundary, so wrap lands on zero.
    assign next_local_d = cur_local_q + ChipAddrBits'({chunk_q, 1'b0});
    assign next_chip_d  = (32'(cur_chip_q) == NumChips - 1) ? '0 : cur_chip_q + CsWidth'(1);

    // Command FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cur_chip_q  <= '0;
            cur_local_q <= '0;
            rem_q       <= '0;
            chunk_q     <= '0;
            write_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_cs_q    <= '0;
            out_addr_q  <= '0;
            out_len_q   <= '0;
            out_write_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        if (in_bad_d) begin
                            err_q <= 1'b1;
                        end else begin
                            cur_chip_q  <= in_chip_d;
                            cur_local_q <= {in_addr_i[ChipAddrBits-1:1], 1'b0};
                            rem_q       <= RemW'(in_len_i) + RemW'(1);
                            write_q     <= in_write_i;
                            in_ready_q  <= 1'b0;
                            state_q     <= CALC;
                        end
                    end
                end
                CALC: begin
                    chunk_q     <= chunk_d;
                    out_cs_q    <= cur_chip_q;
                    out_addr_q  <= cur_local_q;
                    out_len_q   <= LenWidth'(chunk_d - RemW'(1));
                    out_write_q <= write_q;
                    out_last_q  <= (chunk_d == rem_q);
                    out_valid_q <= 1'b1;
                    state_q     <= EMIT;
                end
                EMIT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            in_ready_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            rem_q       <= rem_q - chunk_q;
                            cur_local_q <= next_local_d;
                            if (next_local_d == '0) cur_chip_q <= next_chip_d;
                            state_q     <= CALC;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_cs_o    = out_cs_q;
    assign out_addr_o  = out_addr_q;
    assign out_len_o   = out_len_q;
    assign out_write_o = out_write_q;
    assign out_last_o  = out_last_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_hyper_burst_splitter.sv
// Bench for hyper_burst_splitter: a linear-address reference model predicts
// every PHY transaction, its exact cycle, in_ready_o and err_o.
`timescale 1ns/1ps
module tb_hyper_burst_splitter;

    localparam longint unsigned CHIP = 64'd1 << 23;

    typedef struct {
        int unsigned cs;
        int unsigned addr;
        int unsigned len;
        bit          wr;
        bit          last;
    } txn_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i, in_ready_o, in_write_i;
    logic [31:0] in_addr_i;
    logic [15:0] in_len_i;
    logic        out_valid_o, out_ready_i, out_write_o, out_last_o, err_o;
    logic [0:0]  out_cs_o;
    logic [22:0] out_addr_o;
    logic [15:0] out_len_o;

    logic        in_valid2, in_ready2, in_write2;
    logic [31:0] in_addr2;
    logic [15:0] in_len2;
    logic        out_valid2, out_ready2, out_write2, out_last2, err2;
    logic [1:0]  out_cs2;
    logic [22:0] out_addr2;
    logic [15:0] out_len2;

    hyper_burst_splitter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_addr_i(in_addr_i),
        .in_len_i(in_len_i), .in_write_i(in_write_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_cs_o(out_cs_o),
        .out_addr_o(out_addr_o), .out_len_o(out_len_o), .out_write_o(out_write_o),
        .out_last_o(out_last_o), .err_o(err_o)
    );

    // Three chips and a small burst limit, so the drop path and modulo wrap are reachable.
    hyper_burst_splitter #(.MaxBurstWords(4), .NumChips(3)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid2), .in_ready_o(in_ready2), .in_addr_i(in_addr2),
        .in_len_i(in_len2), .in_write_i(in_write2),
        .out_valid_o(out_valid2), .out_ready_i(out_ready2), .out_cs_o(out_cs2),
        .out_addr_o(out_addr2), .out_len_o(out_len2), .out_write_o(out_write2),
        .out_last_o(out_last2), .err_o(err2)
    );

    always #5 clk_i = ~clk_i;

    int      checks = 0;
    int      failures = 0;
    longint  cyc = 0;
    longint  exp_appear = 0;
    bit      chk_en = 1'b0;
    bit      err_due = 1'b0;
    int      rdy_mode = 0;
    int      stall = 0;
    txn_t    exp_q[$];
    txn_t    mdl_q[$];
    bit      mdl_err;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Walk a linear address space of nch chips, cutting at max burst and chip boundaries.
    function automatic void model(input logic [31:0] a, input int unsigned len,
                                  input int unsigned nch, input int unsigned maxb, input bit wr);
        int unsigned     csw;
        longint unsigned chip, g, rem, bnd, chunk;
        txn_t            t;
        csw = 1;
        while ((32'd1 << csw) < nch) csw++;
        mdl_q.delete();
        mdl_err = 1'b0;
        chip = (64'(a) >> 23) & ((64'd1 << csw) - 1);
        if (chip >= 64'(nch)) begin
            mdl_err = 1'b1;
            return;
        end
        g   = chip * CHIP + (64'(a) & (CHIP - 1) & ~64'd1);
        rem = 64'(len) + 1;
        while (rem != 0) begin
            bnd   = (CHIP - g % CHIP) / 2;
            chunk = rem;
            if (64'(maxb) < chunk) chunk = 64'(maxb);
            if (bnd < chunk) chunk = bnd;
            t.cs   = 32'(g / CHIP);
            t.addr = 32'(g % CHIP);
            t.len  = 32'(chunk - 1);
            t.wr   = wr;
            t.last = (chunk == rem);
            mdl_q.push_back(t);
            rem = rem - chunk;
            g   = (g + 2 * chunk) % (64'(nch) * CHIP);
        end
    endfunction

    // Compare process: valid timing, ready, err and held fields every cycle.
    initial forever begin : compare
        bit exp_v;
        @(negedge clk_i);
        if (chk_en) begin
            exp_v = (exp_q.size() != 0) && (cyc >= exp_appear);
            chk("out_valid", 64'(out_valid_o), 64'(exp_v));
            chk("in_ready", 64'(in_ready_o), 64'(exp_q.size() == 0));
            chk("err", 64'(err_o), 64'(err_due));
            if (out_valid_o && exp_v) begin
                chk("out_cs", 64'(out_cs_o), 64'(exp_q[0].cs));
                chk("out_addr", 64'(out_addr_o), 64'(exp_q[0].addr));
                chk("out_len", 64'(out_len_o), 64'(exp_q[0].len));
                chk("out_write", 64'(out_write_o), 64'(exp_q[0].wr));
                chk("out_last", 64'(out_last_o), 64'(exp_q[0].last));
                if (out_ready_i) begin
                    void'(exp_q.pop_front());
                    exp_appear = cyc + 2;
                end
            end
        end
    end

    // out_ready_i generator: 0 always, 1 random, 2 low for 5 cycles per txn, 3 manual.
    initial forever begin : ready_gen
        @(posedge clk_i);
        #1;
        case (rdy_mode)
            0: out_ready_i = 1'b1;
            1: out_ready_i = ($urandom_range(0, 2) != 0);
            2: begin
                if (!out_valid_o) begin
                    stall = 0;
                    out_ready_i = 1'b0;
                end else if (stall < 5) begin
                    stall++;
                    out_ready_i = 1'b0;
                end else begin
                    out_ready_i = 1'b1;
                end
            end
            default: ;
        endcase
    end

    task automatic send_begin(input logic [31:0] a, input int unsigned len, input bit wr);
        bit ok;
        in_valid_i = 1'b1;
        in_addr_i  = a;
        in_len_i   = 16'(len);
        in_write_i = wr;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        if (!ok) begin
            chk("in_handshake_timeout", 64'd0, 64'd1);
            return;
        end
        model(a, len, 2, 256, wr);
        if (mdl_err) begin
            err_due = 1'b1;
            @(posedge clk_i);
            #1;
            err_due = 1'b0;
        end else begin
            foreach (mdl_q[j]) exp_q.push_back(mdl_q[j]);
            exp_appear = cyc + 1;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20000; i++) begin
            if (exp_q.size() == 0) return;
            @(posedge clk_i);
            #1;
        end
        chk("txn_drain_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic run(input logic [31:0] a, input int unsigned len, input bit wr);
        send_begin(a, len, wr);
        wait_done();
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50; i++) begin
            if (out_valid_o) return;
            @(posedge clk_i);
            #1;
        end
        chk("wait_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic run2(input logic [31:0] a, input int unsigned len);
        bit ok;
        in_valid2 = 1'b1;
        in_addr2  = a;
        in_len2   = 16'(len);
        in_write2 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (in_ready2) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_i);
        #1;
        in_valid2 = 1'b0;
        chk("i2_in_handshake", 64'(ok), 64'd1);
        model(a, len, 3, 4, 1'b1);
        chk("i2_err", 64'(err2), 64'(mdl_err));
        if (mdl_err) begin
            repeat (4) begin
                @(posedge clk_i);
                #1;
                chk("i2_no_valid", 64'(out_valid2), 64'd0);
                chk("i2_err_single", 64'(err2), 64'd0);
                chk("i2_ready_kept", 64'(in_ready2), 64'd1);
            end
        end else begin
            foreach (mdl_q[j]) begin
                ok = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    if (out_valid2) begin
                        ok = 1'b1;
                        break;
                    end
                    @(posedge clk_i);
                    #1;
                end
                chk("i2_valid", 64'(ok), 64'd1);
                chk("i2_cs", 64'(out_cs2), 64'(mdl_q[j].cs));
                chk("i2_addr", 64'(out_addr2), 64'(mdl_q[j].addr));
                chk("i2_len", 64'(out_len2), 64'(mdl_q[j].len));
                chk("i2_last", 64'(out_last2), 64'(mdl_q[j].last));
                out_ready2 = 1'b1;
                @(posedge clk_i);
                #1;
                out_ready2 = 1'b0;
            end
        end
    endtask

    initial begin : driver
        rst_i = 1'b1;
        in_valid_i = 1'b0; in_addr_i = '0; in_len_i = '0; in_write_i = 1'b0;
        out_ready_i = 1'b1;
        in_valid2 = 1'b0; in_addr2 = '0; in_len2 = '0; in_write2 = 1'b0;
        out_ready2 = 1'b0;

        // Hand-computed expectations that pin the model.
        model(32'h0000_0100, 15, 2, 256, 1'b0);
        chk("pin_t1_count", 64'(mdl_q.size()), 64'd1);
        chk("pin_t1_addr", 64'(mdl_q[0].addr), 64'h100);
        model(32'h0000_0000, 599, 2, 256, 1'b0);
        chk("pin_t2_count", 64'(mdl_q.size()), 64'd3);
        chk("pin_t2_addr1", 64'(mdl_q[1].addr), 64'h200);
        chk("pin_t2_len2", 64'(mdl_q[2].len), 64'd87);
        model(32'h007F_FFF0, 15, 2, 256, 1'b0);
        chk("pin_t3_len0", 64'(mdl_q[0].len), 64'd7);
        chk("pin_t3_last0", 64'(mdl_q[0].last), 64'd0);
        chk("pin_t3_cs1", 64'(mdl_q[1].cs), 64'd1);
        model(32'h00FF_FFFC, 3, 2, 256, 1'b0);
        chk("pin_t4_addr0", 64'(mdl_q[0].addr), 64'h7FFFFC);
        chk("pin_t4_cs_wrap", 64'(mdl_q[1].cs), 64'd0);
        model(32'h0180_0000, 0, 3, 4, 1'b0);
        chk("pin_drop", 64'(mdl_err), 64'd1);

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_out_fields", 64'({out_cs_o, out_addr_o, out_len_o, out_write_o, out_last_o}), 64'd0);
        chk("rst2_in_ready", 64'(in_ready2), 64'd1);
        rst_i = 1'b0;
        chk_en = 1'b1;

        run(32'h0000_0100, 15, 1'b0);
        run(32'h0000_0000, 599, 1'b1);
        run(32'h007F_FFF0, 15, 1'b0);
        run(32'h00FF_FFFC, 3, 1'b1);

        rdy_mode = 2;
        run(32'h0000_0000, 599, 1'b0);
        // Bit 24 sits above the one-bit chip field and is ignored.
        run(32'h0100_0000, 7, 1'b1);
        rdy_mode = 0;

        // Largest command, starting odd near the end of chip 1, wrapping to chip 0.
        run(32'h00FF_0001, 65535, 1'b1);

        // Reset while the second chunk is presented.
        rdy_mode = 3;
        out_ready_i = 1'b0;
        send_begin(32'h0000_0000, 599, 1'b0);
        wait_valid();
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        wait_valid();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        exp_q.delete();
        err_due = 1'b0;
        chk("midrst_out_valid", 64'(out_valid_o), 64'd0);
        chk("midrst_in_ready", 64'(in_ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        rdy_mode = 0;
        run(32'h0000_0100, 15, 1'b0);

        rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            int unsigned l;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[22:0] = 23'h7FFFFF - 23'($urandom_range(0, 1200));
            l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 900);
            run(a, l, 1'($urandom_range(0, 1)));
        end
        rdy_mode = 0;

        run2(32'h0180_0000, 3);
        run2(32'h0000_0000, 9);
        run2(32'h017F_FFFA, 5);
        run2(32'h0080_0002, 0);

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
